seg7_to_binary: RTL and testbench

- Decodes the two-digit 7-segment display pin pattern back into the 8-bit hex value it represents.
- Provides a loop-back monitor on the display pins, for self-check of the display path on the board and in benches.
- Filters glitches with a stability window, so only settled patterns are decoded.
- Flags patterns that are not valid hex glyphs and counts them.

---
 rtl/seg7_to_binary.sv | 118 +++++++++++
 tb/tb_seg7_to_binary.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_to_binary.sv
// Loop-back monitor for a two-digit 7-segment display: waits for the pin pattern
// to settle, decodes it back to the 8-bit hex value, and tracks undecodable glyphs.
module seg7_to_binary #(
   parameter int c_STABLE_CYCLES = 4,
   parameter bit c_ACTIVE_LOW    = 1'b1
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic [6:0] i_Seg1,
   input  logic [6:0] i_Seg2,
   output logic [7:0] o_Value,
   output logic       o_Valid,
   output logic       o_Locked,
   output logic       o_Invalid,
   output logic [7:0] o_Err_Count
);

   localparam logic [1:0] s_IDLE     = 2'd0;
   localparam logic [1:0] s_SETTLING = 2'd1;
   localparam logic [1:0] s_LOCKED   = 2'd2;

   localparam logic [13:0] c_POL_MASK   = c_ACTIVE_LOW ? 14'h3FFF : 14'h0000;
   localparam logic [8:0]  c_LOCK_COUNT = 9'(c_STABLE_CYCLES);

   // Returns {glyph_ok, nibble}; blank and unknown patterns both report glyph_ok=0.
   function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
      logic [4:0] result;
      case (seg)
         7'h7E:   result = 5'h10;
         7'h30:   result = 5'h11;
         7'h6D:   result = 5'h12;
         7'h79:   result = 5'h13;
         7'h33:   result = 5'h14;
         7'h5B:   result = 5'h15;
         7'h5F:   result = 5'h16;
         7'h70:   result = 5'h17;
         7'h7F:   result = 5'h18;
         7'h7B:   result = 5'h19;
         7'h77:   result = 5'h1A;
         7'h1F:   result = 5'h1B;
         7'h4E:   result = 5'h1C;
         7'h3D:   result = 5'h1D;
         7'h4F:   result = 5'h1E;
         7'h47:   result = 5'h1F;
         default: result = 5'h00;
      endcase
      return result;
   endfunction

   logic [13:0] r_In;
   logic [13:0] r_Prev;
   logic [7:0]  r_Count;
   logic [1:0]  r_State;

   logic [4:0] w_Dig1;
   logic [4:0] w_Dig2;
   logic       w_Blank;
   logic       w_Good;
   logic       w_Restart;
   logic [8:0] w_Next_Count;

   assign w_Dig1       = decode_glyph(r_In[13:7]);
   assign w_Dig2       = decode_glyph(r_In[6:0]);
   assign w_Blank      = (r_In == 14'h0000);
   assign w_Good       = w_Dig1[4] & w_Dig2[4];
   assign w_Next_Count = {1'b0, r_Count} + 9'd1;
   assign w_Restart    = ((r_State != s_SETTLING) && (r_State != s_LOCKED)) || (r_In != r_Prev);

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_In <= 14'h0000;
      end else begin
         r_In <= {i_Seg1, i_Seg2} ^ c_POL_MASK;
      end
   end

   // Any difference from the previous sample restarts the window, even on the lock edge.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_Prev      <= 14'h0000;
         r_Count     <= 8'd0;
         r_State     <= s_IDLE;
         o_Value     <= 8'h00;
         o_Valid     <= 1'b0;
         o_Locked    <= 1'b0;
         o_Invalid   <= 1'b0;
         o_Err_Count <= 8'h00;
      end else begin
         o_Valid <= 1'b0;
         if (w_Restart) begin
            r_Prev   <= r_In;
            r_Count  <= 8'd1;
            r_State  <= s_SETTLING;
            o_Locked <= 1'b0;
         end else if (r_State == s_SETTLING) begin
            if (w_Next_Count < c_LOCK_COUNT) begin
               r_Count <= w_Next_Count[7:0];
            end else begin
               r_State  <= s_LOCKED;
               o_Locked <= 1'b1;
               if (w_Good) begin
                  o_Value   <= {w_Dig1[3:0], w_Dig2[3:0]};
                  o_Valid   <= 1'b1;
                  o_Invalid <= 1'b0;
               end else if (w_Blank) begin
                  o_Invalid <= 1'b0;
               end else begin
                  o_Invalid <= 1'b1;
                  if (o_Err_Count != 8'hFF) begin
                     o_Err_Count <= o_Err_Count + 8'd1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_to_binary.sv
// Randomised bench for seg7_to_binary: a run-length reference model predicts every
// output each cycle, and scenario tasks add targeted latency and boundary checks.
module tb_seg7_to_binary;

   localparam int STABLE = 4;

   logic       i_Clk = 1'b0;
   logic       i_Rst;
   logic [6:0] i_Seg1;
   logic [6:0] i_Seg2;
   logic [7:0] o_Value;
   logic       o_Valid;
   logic       o_Locked;
   logic       o_Invalid;
   logic [7:0] o_Err_Count;

   int vectors = 0;
   int miscompares = 0;

   logic [6:0] glyphTable [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   // Reference model state: the sampled pattern and how many edges it has been seen in a row.
   logic [13:0] mIn = '0;
   logic [13:0] mLast = '0;
   int          runLen = 0;
   logic [7:0]  mValue = '0;
   logic        mValid = 1'b0;
   logic        mLocked = 1'b0;
   logic        mInvalid = 1'b0;
   logic [7:0]  mErr = '0;

   seg7_to_binary #(.c_STABLE_CYCLES(STABLE), .c_ACTIVE_LOW(1'b1)) dut (
      .i_Clk      (i_Clk),
      .i_Rst      (i_Rst),
      .i_Seg1     (i_Seg1),
      .i_Seg2     (i_Seg2),
      .o_Value    (o_Value),
      .o_Valid    (o_Valid),
      .o_Locked   (o_Locked),
      .o_Invalid  (o_Invalid),
      .o_Err_Count(o_Err_Count)
   );

   always #20 i_Clk = ~i_Clk;

   function automatic int glyph_index(input logic [6:0] pat);
      for (int i = 0; i < 16; i++) begin
         if (glyphTable[i] == pat) return i;
      end
      return -1;
   endfunction

   function automatic logic [6:0] random_invalid();
      logic [6:0] pat;
      do pat = 7'($urandom); while (pat == 7'h00 || glyph_index(pat) >= 0);
      return pat;
   endfunction

   // Drives active-high digit patterns onto the active-low pins for one clock and steps the model.
   task automatic applyStimulus(input logic [6:0] dig1, input logic [6:0] dig2, input logic rst);
      logic [13:0] pre;
      int hi;
      int lo;
      i_Seg1 = ~dig1;
      i_Seg2 = ~dig2;
      i_Rst  = rst;
      @(posedge i_Clk);
      if (rst) begin
         mIn = '0; mLast = '0; runLen = 0;
         mValue = '0; mValid = 1'b0; mLocked = 1'b0; mInvalid = 1'b0; mErr = '0;
      end else begin
         pre = mIn;
         runLen = (runLen > 0 && pre == mLast) ? runLen + 1 : 1;
         mLast = pre;
         mValid = 1'b0;
         mLocked = (runLen >= STABLE);
         if (runLen == STABLE) begin
            hi = glyph_index(pre[13:7]);
            lo = glyph_index(pre[6:0]);
            if (pre == 14'h0) begin
               mInvalid = 1'b0;
            end else if (hi >= 0 && lo >= 0) begin
               mValue = {4'(hi), 4'(lo)};
               mValid = 1'b1;
               mInvalid = 1'b0;
            end else begin
               mInvalid = 1'b1;
               if (mErr != 8'hFF) mErr = mErr + 8'd1;
            end
         end
         mIn = {dig1, dig2};
      end
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         applyStimulus(7'h7E, 7'h7E, 1'b1);
         vectors++;
         if ({o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count} !== 19'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %h expected 0",
                     {o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count});
         end
      end
   endtask

   task automatic test_valid_decode();
      int pulses = 0;
      int pulseStep = 0;
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(7'h79, 7'h77, 1'b0);
         vectors++;
         if ({o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count} !==
             {mValue, mValid, mLocked, mInvalid, mErr}) begin
            miscompares++;
            $display("[TB] FAIL decode_3A step %0d: got %h expected %h", k,
                     {o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count},
                     {mValue, mValid, mLocked, mInvalid, mErr});
         end
         if (o_Valid) begin
            pulses++;
            pulseStep = k;
         end
      end
      vectors++;
      if (pulses != 1 || pulseStep != 1 + STABLE || o_Value !== 8'h3A) begin
         miscompares++;
         $display("[TB] FAIL decode_3A_latency: got pulses=%0d at step %0d value %h, expected 1 at step %0d value 3a",
                  pulses, pulseStep, o_Value, 1 + STABLE);
      end
   endtask

   task automatic test_glitch();
      int pulses = 0;
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(7'h79, (k <= 2) ? 7'h30 : 7'h77, 1'b0);
         vectors++;
         if ({o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count} !==
             {mValue, mValid, mLocked, mInvalid, mErr}) begin
            miscompares++;
            $display("[TB] FAIL glitch step %0d: got %h expected %h", k,
                     {o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count},
                     {mValue, mValid, mLocked, mInvalid, mErr});
         end
         if (k == 2) begin
            vectors++;
            if (o_Locked !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL glitch_unlock: got locked=%b expected 0", o_Locked);
            end
         end
         if (o_Valid) pulses++;
         if (o_Valid && o_Value == 8'h31) begin
            miscompares++;
            $display("[TB] FAIL glitch_decoded: got value 31 pulse, expected none");
         end
      end
      vectors++;
      if (pulses != 1 || o_Value !== 8'h3A) begin
         miscompares++;
         $display("[TB] FAIL glitch_relock: got pulses=%0d value %h expected 1 pulse value 3a", pulses, o_Value);
      end
   endtask

   task automatic test_invalid();
      int pulses = 0;
      for (int k = 1; k <= 100; k++) begin
         applyStimulus(7'h55, 7'h7E, 1'b0);
         vectors++;
         if ({o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count} !==
             {mValue, mValid, mLocked, mInvalid, mErr}) begin
            miscompares++;
            $display("[TB] FAIL invalid step %0d: got %h expected %h", k,
                     {o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count},
                     {mValue, mValid, mLocked, mInvalid, mErr});
         end
         if (o_Valid) pulses++;
      end
      vectors++;
      if (o_Err_Count !== 8'd1 || o_Invalid !== 1'b1 || o_Value !== 8'h3A || pulses != 0) begin
         miscompares++;
         $display("[TB] FAIL invalid_hold: got err=%0d inv=%b value %h pulses=%0d expected 1 1 3a 0",
                  o_Err_Count, o_Invalid, o_Value, pulses);
      end
   endtask

   task automatic test_saturation();
      logic [6:0] prev = 7'h55;
      logic [6:0] pat;
      for (int p = 0; p < 300; p++) begin
         do pat = random_invalid(); while (pat == prev);
         prev = pat;
         for (int k = 0; k < 5; k++) begin
            applyStimulus(pat, 7'h7E, 1'b0);
            vectors++;
            if ({o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count} !==
                {mValue, mValid, mLocked, mInvalid, mErr}) begin
               miscompares++;
               $display("[TB] FAIL saturation pattern %0d: got %h expected %h", p,
                        {o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count},
                        {mValue, mValid, mLocked, mInvalid, mErr});
            end
         end
      end
      vectors++;
      if (o_Err_Count !== 8'hFF) begin
         miscompares++;
         $display("[TB] FAIL err_saturate: got %h expected ff", o_Err_Count);
      end
   endtask

   task automatic test_blank();
      int pulses = 0;
      applyStimulus(7'h00, 7'h00, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(7'h00, 7'h00, 1'b0);
         vectors++;
         if ({o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count} !==
             {mValue, mValid, mLocked, mInvalid, mErr}) begin
            miscompares++;
            $display("[TB] FAIL blank step %0d: got %h expected %h", k,
                     {o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count},
                     {mValue, mValid, mLocked, mInvalid, mErr});
         end
         if (o_Valid) pulses++;
      end
      vectors++;
      if (o_Locked !== 1'b1 || o_Invalid !== 1'b0 || o_Value !== 8'h00 || pulses != 0) begin
         miscompares++;
         $display("[TB] FAIL blank_lock: got lock=%b inv=%b value %h pulses=%0d expected 1 0 00 0",
                  o_Locked, o_Invalid, o_Value, pulses);
      end
   endtask

   task automatic test_reset_abort();
      int pulseStep = 0;
      applyStimulus(7'h47, 7'h7E, 1'b0);
      applyStimulus(7'h47, 7'h7E, 1'b0);
      applyStimulus(7'h47, 7'h7E, 1'b1);
      vectors++;
      if ({o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count} !== 19'h0) begin
         miscompares++;
         $display("[TB] FAIL abort_reset: got %h expected 0",
                  {o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count});
      end
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(7'h47, 7'h7E, 1'b0);
         vectors++;
         if ({o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count} !==
             {mValue, mValid, mLocked, mInvalid, mErr}) begin
            miscompares++;
            $display("[TB] FAIL abort step %0d: got %h expected %h", k,
                     {o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count},
                     {mValue, mValid, mLocked, mInvalid, mErr});
         end
         if (o_Valid && pulseStep == 0) pulseStep = k;
      end
      vectors++;
      if (pulseStep != STABLE + 1 || o_Value !== 8'hF0) begin
         miscompares++;
         $display("[TB] FAIL abort_relock: got pulse at %0d value %h expected %0d value f0",
                  pulseStep, o_Value, STABLE + 1);
      end
   endtask

   task automatic test_random();
      logic [6:0] d1;
      logic [6:0] d2;
      int hold;
      for (int p = 0; p < 80; p++) begin
         if ($urandom_range(9) < 7) begin
            d1 = glyphTable[$urandom_range(15)];
            d2 = glyphTable[$urandom_range(15)];
         end else begin
            d1 = 7'($urandom);
            d2 = ($urandom_range(3) == 0) ? 7'h00 : 7'($urandom);
         end
         hold = $urandom_range(7, 1);
         for (int k = 0; k < hold; k++) begin
            applyStimulus(d1, d2, ($urandom_range(60) == 0));
            vectors++;
            if ({o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count} !==
                {mValue, mValid, mLocked, mInvalid, mErr}) begin
               miscompares++;
               $display("[TB] FAIL random pattern %0d: got %h expected %h", p,
                        {o_Value, o_Valid, o_Locked, o_Invalid, o_Err_Count},
                        {mValue, mValid, mLocked, mInvalid, mErr});
            end
         end
      end
   endtask

   initial begin
      i_Rst  = 1'b1;
      i_Seg1 = 7'h7F;
      i_Seg2 = 7'h7F;
      #5;
      test_reset();
      test_valid_decode();
      test_glitch();
      test_invalid();
      test_saturation();
      test_blank();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
